// File: rtl/cmp_share_arbiter_pkg.sv
// cmp_share_pkg: shared types, defaults and the round-robin picker for cmp_share_arbiter
package cmp_share_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int MAX_NREQ  = 32;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // first valid requester at or after ptr, wrapping modulo nreq
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid, input logic [4:0] ptr, input logic [5:0] nreq);
        pick_t      p;
        logic [5:0] j;
        p = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            j = {1'b0, ptr} + 6'(k);
            j = (j >= nreq) ? j - nreq : j;
            if (6'(k) < nreq && !p.found && valid[j[4:0]]) begin
                p.found = 1'b1;
                p.idx   = j[4:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// cmp_share_arbiter_if: request/response bundle between compare clients and the shared comparator
interface cmp_share_arbiter_if #(
    parameter int WIDTH = cmp_share_pkg::DEF_WIDTH,
    parameter int NREQ  = cmp_share_pkg::DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_equal;
    logic                  rsp_greater;
    logic                  rsp_less;
    logic                  err_onehot;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_equal, rsp_greater, rsp_less, err_onehot
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_equal, rsp_greater, rsp_less, err_onehot
    );
endinterface

// File: rtl/cmp_share_arbiter_param_comparator.sv
// param_comparator: unsigned equal/greater/less of two WIDTH-bit operands
module param_comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);
    assign eq_o = a_i == b_i;
    assign gt_o = a_i > b_i;
    assign lt_o = a_i < b_i;
endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin share of one param_comparator among NREQ requesters
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input logic              clk,
    input logic              rst,
    cmp_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d, id_q, id_d, rsp_id_q, rsp_id_d, win;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d, err_q, err_d;
    logic             c_eq, c_gt, c_lt;
    logic [NREQ-1:0]  req_ready;
    pick_t            pick;

    assign pick = rr_pick(32'(bus.req_valid), 5'(rr_q), 6'(NREQ));
    assign win  = IDW'(pick.idx);

    param_comparator #(.WIDTH(WIDTH)) u_cmp (
        .a_i  (a_q),
        .b_i  (b_q),
        .eq_o (c_eq),
        .gt_o (c_gt),
        .lt_o (c_lt)
    );

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_equal   = eq_q;
    assign bus.rsp_greater = gt_q;
    assign bus.rsp_less    = lt_q;
    assign bus.err_onehot  = err_q;

    // grant in IDLE (never while rst is high), capture the comparator result in CMP, hold it in RESP
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        err_d       = err_q;
        req_ready   = '0;
        case (state_q)
            IDLE: if (pick.found && !rst) begin
                req_ready[win] = 1'b1;
                a_d            = bus.req_a[win*WIDTH +: WIDTH];
                b_d            = bus.req_b[win*WIDTH +: WIDTH];
                id_d           = win;
                rr_d           = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                state_d        = CMP;
            end
            CMP: begin
                eq_d        = c_eq;
                gt_d        = c_gt;
                lt_d        = c_lt;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                err_d       = err_q | !$onehot({c_eq, c_gt, c_lt});
                state_d     = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed stimulus with a response scoreboard for cmp_share_arbiter
module tb_cmp_share_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A[4];
    logic [7:0] B[4];
    logic [4:0] sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    cmp_share_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();
    cmp_share_arbiter #(.WIDTH(8), .NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.req_a = {A[3], A[2], A[1], A[0]};
    assign bus.req_b = {B[3], B[2], B[1], B[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
        return {a == b, a > b, a < b};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int g);
        #1;
        chk($sformatf("grant%0d", g), 32'(bus.req_ready), 32'(1) << g);
        sb.push_back({2'(g), model(A[g], B[g])});
    endtask

    task automatic no_grant(input string tag);
        #1;
        chk(tag, 32'(bus.req_ready), 32'(0));
    endtask

    // pop the oldest expected response whenever one is handed over
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL rsp_unexpected: observed id %0d with empty scoreboard", bus.rsp_id);
            end
            if (sb.size() > 0)
                chk("rsp", 32'({bus.rsp_id, bus.rsp_equal, bus.rsp_greater, bus.rsp_less}), 32'(sb.pop_front()));
            chk("rsp_err_onehot", 32'(bus.err_onehot), 32'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A[i] = '0;
            B[i] = '0;
        end
        cyc();
        bus.req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
        chk("rst_flags", 32'({bus.rsp_equal, bus.rsp_greater, bus.rsp_less}), 32'(0));
        chk("rst_err", 32'(bus.err_onehot), 32'(0));
        cyc();
        bus.req_valid = '0;
        rst           = 1'b0;

        A[0] = 8'h5A; B[0] = 8'h5A;
        bus.req_valid = 4'b0001;
        grant(0);
        cyc();
        bus.req_valid = '0;
        no_grant("s1_cmp_ready");
        cyc();
        #1;
        chk("s1_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        chk("s1_rsp", 32'({bus.rsp_id, bus.rsp_equal, bus.rsp_greater, bus.rsp_less}), 32'({2'd0, 3'b100}));
        cyc();
        #1;
        chk("s1_rsp_done", 32'(bus.rsp_valid), 32'(0));

        rst = 1'b1;
        cyc();
        rst  = 1'b0;
        A[0] = 8'hFF; B[0] = 8'h00;
        A[1] = 8'h00; B[1] = 8'hFF;
        A[2] = 8'h80; B[2] = 8'h7F;
        A[3] = 8'h01; B[3] = 8'h01;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            grant(k % 4);
            cyc();
            if (k == 4) bus.req_valid = '0;
            no_grant("rr_cmp_ready");
            cyc();
            cyc();
        end

        A[0] = 8'h33; B[0] = 8'h44;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        grant(0);
        cyc();
        bus.req_valid = 4'b0010;
        no_grant("bp_cmp_ready");
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", 32'(bus.rsp_valid), 32'(1));
            chk("bp_fields", 32'({bus.rsp_id, bus.rsp_equal, bus.rsp_greater, bus.rsp_less}), 32'({2'd0, 3'b001}));
            chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
            cyc();
        end
        bus.rsp_ready = 1'b1;
        no_grant("bp_release_ready");
        cyc();
        grant(1);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();

        A[3] = 8'hFF; B[3] = 8'hFF;
        bus.req_valid = 4'b1000;
        grant(3);
        cyc();
        bus.req_valid = 4'b1010;
        cyc();
        cyc();
        grant(1);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();

        A[2] = 8'h10; B[2] = 8'h20;
        bus.req_valid = 4'b0100;
        #1;
        chk("abort_grant2", 32'(bus.req_ready), 32'(4'b0100));
        cyc();
        bus.req_valid = 4'hF;
        rst           = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("abort_req_ready", 32'(bus.req_ready), 32'(0));
        cyc();
        #1;
        chk("abort_rsp_valid2", 32'(bus.rsp_valid), 32'(0));
        rst = 1'b0;
        grant(0);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();

        #1;
        chk("final_err", 32'(bus.err_onehot), 32'(0));
        chk("final_sb_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
